uo_share_arbiter: RTL and testbench

- Shares the single 8-bit user output port (uo_out) between N_REQ requesters driven from user input pins (ui_in bits).
- Each requester raises a request pulse and receives exclusive use of the output for a fixed hold window.
- Grants rotate round-robin.
- Sits between the pin-level wrapper and uo_out: synchronises raw pins, latches request edges, and sequences grants.

---
 rtl/uo_arb_pkg.sv | 24 ++
 rtl/req_edge_sync.sv | 29 ++
 rtl/uo_share_arbiter.sv | 137 +++++++++++++
 tb/tb_uo_share_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uo_arb_pkg.sv
// rtl/uo_arb_pkg.sv - shared FSM type and helpers for the uo_out share arbiter
package uo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int MAX_REQ = 8;

    // Keeps the hold counter at least one bit wide when HOLD_CYC is 1.
    function automatic int cnt_width(input int hold_cyc);
        return (hold_cyc > 1) ? $clog2(hold_cyc) : 1;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input logic [31:0] idx);
        logic [MAX_REQ-1:0] v;
        v = '0;
        v[idx[2:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/req_edge_sync.sv
// rtl/req_edge_sync.sv - synchronise one raw request pin and emit a registered one-cycle rise pulse
module req_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic                   r_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
            r_dly  <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_dly;
        end
    end

    assign rise_o = r_rise;

endmodule

// File: rtl/uo_share_arbiter.sv
// rtl/uo_share_arbiter.sv - time-shares uo_out between N_REQ pin requesters in fixed hold windows
// Define UO_ARB_FIXED_PRIO_EN to make the lowest pending index win instead of round-robin.
module uo_share_arbiter
    import uo_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYC    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [DATA_W-1:0]       out_o,
    output logic                    out_valid_o,
    output logic [N_REQ-1:0]        pend_o,
    output logic                    busy_o
);

    localparam int             CW        = cnt_width(HOLD_CYC);
    localparam int             IW        = $clog2(N_REQ);
    localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_CYC - 1);

    arb_state_t        r_state, w_state_n;
    logic [CW-1:0]     r_cnt, w_cnt_n;
    logic [N_REQ-1:0]  r_pend, w_pend_n;
    logic [N_REQ-1:0]  r_gnt, w_gnt_n;
    logic [DATA_W-1:0] r_out, w_out_n;
    logic              r_valid, w_valid_n;
    logic [N_REQ-1:0]  w_rise;
    logic              w_found;
    logic [IW-1:0]     w_win, w_cand;
`ifndef UO_ARB_FIXED_PRIO_EN
    logic [IW-1:0]     r_ptr, w_ptr_n;
`endif

    for (genvar k = 0; k < N_REQ; k++) begin : g_sync
        req_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .d_i    (req_i[k]),
            .rise_o (w_rise[k])
        );
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef UO_ARB_FIXED_PRIO_EN
            w_cand = IW'(i);
`else
            w_cand = IW'((int'(r_ptr) + i) % N_REQ);
`endif
            if (!w_found && r_pend[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_pend_n  = r_pend;
        w_gnt_n   = r_gnt;
        w_out_n   = r_out;
        w_valid_n = r_valid;
`ifndef UO_ARB_FIXED_PRIO_EN
        w_ptr_n   = r_ptr;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_n        = ST_GRANT;
                    w_gnt_n          = N_REQ'(onehot(32'(w_win)));
                    w_out_n          = data_i[w_win*DATA_W +: DATA_W];
                    w_valid_n        = 1'b1;
                    w_cnt_n          = HOLD_LOAD;
                    w_pend_n[w_win]  = 1'b0;
`ifndef UO_ARB_FIXED_PRIO_EN
                    // ptr is only consulted in IDLE, so advancing it at grant time is equivalent.
                    w_ptr_n = (w_win == IW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
`endif
                end
            end
            ST_GRANT: begin
                if (r_cnt == '0) begin
                    w_state_n = ST_GAP;
                    w_gnt_n   = '0;
                    w_out_n   = '0;
                    w_valid_n = 1'b0;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            ST_GAP:  w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
        // A fresh edge wins over the clear so a re-request is never lost.
        w_pend_n = w_pend_n | w_rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_gnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
`ifndef UO_ARB_FIXED_PRIO_EN
            r_ptr   <= '0;
`endif
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_pend  <= w_pend_n;
            r_gnt   <= w_gnt_n;
            r_out   <= w_out_n;
            r_valid <= w_valid_n;
`ifndef UO_ARB_FIXED_PRIO_EN
            r_ptr   <= w_ptr_n;
`endif
        end
    end

    assign gnt_o       = r_gnt;
    assign out_o       = r_out;
    assign out_valid_o = r_valid;
    assign pend_o      = r_pend;
    assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uo_share_arbiter.sv
// tb/tb_uo_share_arbiter.sv - randomized and directed bench for uo_share_arbiter against a cycle-level model
module tb_uo_share_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int HOLD = 16;
    localparam int SS   = 2;
    localparam int DLY  = SS + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]  gnt_o;
    logic [DW-1:0] out_o;
    logic          out_valid_o;
    logic [N-1:0]  pend_o;
    logic          busy_o;

    always #5 clk = ~clk;

    uo_share_arbiter #(
        .N_REQ(N), .DATA_W(DW), .HOLD_CYC(HOLD), .SYNC_STAGES(SS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .data_i      (data_i),
        .gnt_o       (gnt_o),
        .out_o       (out_o),
        .out_valid_o (out_valid_o),
        .pend_o      (pend_o),
        .busy_o      (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: edges counted from reset release, grants as windows in time.
    logic [N-1:0]  m_pend, m_prev_req, m_goh;
    logic [N-1:0]  m_rise_q [DLY];
    logic [DW-1:0] m_gdata;
    int            m_e, m_allow, m_gstart, m_ptr;
    logic [N-1:0]  e_gnt, e_pend;
    logic [DW-1:0] e_out;
    logic          e_valid, e_busy;
    logic [N-1:0]  seen_q [$];
    logic [N-1:0]  prev_gnt;

    task automatic model_reset();
        m_pend = '0; m_prev_req = '0; m_goh = '0; m_gdata = '0;
        for (int i = 0; i < DLY; i++) m_rise_q[i] = '0;
        m_e = 0; m_allow = 0; m_gstart = -1000; m_ptr = 0;
        prev_gnt = '0;
        seen_q.delete();
    endtask

    task automatic model_edge();
        logic [N-1:0] arriving;
        int w, c;
        arriving = m_rise_q[DLY-1];
        for (int i = DLY-1; i > 0; i--) m_rise_q[i] = m_rise_q[i-1];
        m_rise_q[0] = req_i & ~m_prev_req;
        m_prev_req  = req_i;
        if (m_e >= m_allow && m_pend != '0) begin
            w = -1;
            for (int i = 0; i < N; i++) begin
`ifdef UO_ARB_FIXED_PRIO_EN
                c = i;
`else
                c = (m_ptr + i) % N;
`endif
                if (w < 0 && m_pend[c]) w = c;
            end
            m_gstart  = m_e;
            m_allow   = m_e + HOLD + 2;
            m_ptr     = (w + 1) % N;
            m_goh     = N'(1 << w);
            m_gdata   = data_i[w*DW +: DW];
            m_pend[w] = 1'b0;
        end
        m_pend  = m_pend | arriving;
        e_valid = (m_e >= m_gstart) && (m_e < m_gstart + HOLD);
        e_busy  = (m_e >= m_gstart) && (m_e <= m_gstart + HOLD);
        e_gnt   = e_valid ? m_goh : '0;
        e_out   = e_valid ? m_gdata : '0;
        e_pend  = m_pend;
        m_e++;
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic step(input logic [N-1:0] req, input logic [N*DW-1:0] data);
        req_i  = req;
        data_i = data;
        @(posedge clk);
        model_edge();
        #1;
        check("gnt",   32'(gnt_o),       32'(e_gnt));
        check("out",   32'(out_o),       32'(e_out));
        check("valid", 32'(out_valid_o), 32'(e_valid));
        check("pend",  32'(pend_o),      32'(e_pend));
        check("busy",  32'(busy_o),      32'(e_busy));
        if (gnt_o != '0 && prev_gnt == '0) seen_q.push_back(gnt_o);
        prev_gnt = gnt_o;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},   32'(gnt_o),       32'h0);
        check({tag, "_out"},   32'(out_o),       32'h0);
        check({tag, "_valid"}, 32'(out_valid_o), 32'h0);
        check({tag, "_pend"},  32'(pend_o),      32'h0);
        check({tag, "_busy"},  32'(busy_o),      32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_idle("rst");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_i = (i % 2 == 0) ? '1 : '0;
            @(posedge clk);
            #1;
            check_idle("rst_hold");
        end
        @(negedge clk);
        req_i = '0;
        rst   = 1'b0;
        model_reset();
    endtask

    function automatic logic [N-1:0] seen_at(input int i);
        return (seen_q.size() > i) ? seen_q[i] : '0;
    endfunction

    logic [N*DW-1:0] dat;
    logic [N-1:0]    rq;
    logic [N-1:0]    exp_order [5];
    int              lat, hold_cnt;

    initial begin
        rst = 1'b1; req_i = '0; data_i = '0;
        @(negedge clk);

        do_reset();
        for (int k = 0; k < 3; k++) step('0, '0);
        check_idle("post_rst");

        // single request: latency, payload and window length
        do_reset();
        dat = N*DW'($urandom);
        dat[7:0] = 8'hA5;
        lat = -1; hold_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(k < 2 ? 4'b0001 : 4'b0000, dat);
            if (lat < 0 && gnt_o == 4'b0001) begin
                lat = k;
                check("single_data", 32'(out_o), 32'hA5);
            end
            if (out_valid_o) hold_cnt++;
        end
        check("single_latency", lat, 4);
        check("single_hold", hold_cnt, HOLD);

        // simultaneous edges from a fresh pointer
        do_reset();
        for (int k = 0; k < 45; k++) step(k < 2 ? 4'b1010 : 4'b0000, N*DW'($urandom));
        check("simul_count", seen_q.size(), 2);
        check("simul_first", 32'(seen_at(0)), 32'h2);
        check("simul_second", 32'(seen_at(1)), 32'h8);

        // everyone re-pulsing continuously
        do_reset();
        for (int k = 0; k < 110; k++) step((k % 2 == 0) ? 4'b1111 : 4'b0000, N*DW'($urandom));
`ifdef UO_ARB_FIXED_PRIO_EN
        exp_order = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`else
        exp_order = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
`endif
        for (int i = 0; i < 5; i++) check($sformatf("fair_%0d", i), 32'(seen_at(i)), 32'(exp_order[i]));

        // requester 2 re-requests during its own grant, alongside requester 3
        do_reset();
        for (int k = 0; k < 72; k++) begin
            rq = (k < 2) ? 4'b0100 : (k == 10 || k == 11) ? 4'b1100 : 4'b0000;
            step(rq, N*DW'($urandom));
            if (k == 14) begin
                check("rereq_pend2", 32'(pend_o[2]), 32'h1);
                check("rereq_gnt2", 32'(gnt_o), 32'h4);
            end
        end
`ifdef UO_ARB_FIXED_PRIO_EN
        exp_order[0:2] = '{4'h4, 4'h4, 4'h8};
`else
        exp_order[0:2] = '{4'h4, 4'h8, 4'h4};
`endif
        for (int i = 0; i < 3; i++) check($sformatf("rereq_%0d", i), 32'(seen_at(i)), 32'(exp_order[i]));

        // random traffic
        do_reset();
        rq = '0;
        for (int k = 0; k < 700; k++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(2) == 0) rq[b] = ~rq[b];
            step(rq, N*DW'($urandom));
        end

        // reset in the middle of a grant
        do_reset();
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            step(k < 2 ? 4'b0001 : 4'b0000, N*DW'($urandom));
            if (lat < 0 && gnt_o != '0) lat = k;
        end
        check("mid_granted", 32'(out_valid_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("mid_async");
        @(negedge clk);
        req_i = '0;
        rst   = 1'b0;
        model_reset();
        for (int k = 0; k < 30; k++) step('0, N*DW'($urandom));
        check("mid_no_resume", seen_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
